// File: rtl/wb_ram_if.sv
// Wishbone classic bus bundle for wb_ram. Signal names are from the slave's point of view.
interface wb_ram_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic                  cyc_i;
    logic                  stb_i;
    logic [31:0]           adr_i;
    logic [SEL_WIDTH-1:0]  sel_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic                  we_i;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  ack_o;
    logic                  err_o;
    logic                  rty_o;

    modport master (
        output cyc_i, stb_i, adr_i, sel_i, dat_i, we_i,
        input  dat_o, ack_o, err_o, rty_o
    );

    modport slave (
        input  cyc_i, stb_i, adr_i, sel_i, dat_i, we_i,
        output dat_o, ack_o, err_o, rty_o
    );
endinterface

// File: rtl/wb_ram.sv
// Parametrised Wishbone classic slave RAM with byte-lane writes and configurable wait states.
// Define CRUSH_WB_RAM_ERR_EN to answer misaligned or sel_i == 0 hits with err_o instead of ack_o.
module wb_ram #(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          SIZE_BYTES   = 16384,
    parameter int          DATA_WIDTH   = 32,
    parameter int          WAIT_STATES  = 0
) (
    input  logic     clk_i,
    input  logic     rst_i,
    wb_ram_if.slave  bus
);
    localparam int          SEL_WIDTH = DATA_WIDTH / 8;
    localparam int          LSB       = $clog2(SEL_WIDTH);
    localparam int          DEPTH     = SIZE_BYTES / SEL_WIDTH;
    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDRESS};
    localparam logic [32:0] LIMIT_EXT = BASE_EXT + 33'(SIZE_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    logic                  req;
    logic                  hit;
    logic                  bad;
    logic                  enter_resp;
    logic                  wr_en;
    logic                  ack;
    logic [31:0]           offset;
    logic [AW-1:0]         word_idx;
    logic                  unused_offset;

    assign req      = bus.cyc_i & bus.stb_i;
    // 33-bit compare so a window ending exactly at 2^32 does not wrap to zero.
    assign hit      = req && ({1'b0, bus.adr_i} >= BASE_EXT) && ({1'b0, bus.adr_i} < LIMIT_EXT);
    assign offset   = bus.adr_i - BASE_ADDRESS;
    assign word_idx = offset[LSB +: AW];
    assign unused_offset = ^offset;

`ifdef CRUSH_WB_RAM_ERR_EN
    assign bad = ((offset & 32'(SEL_WIDTH - 1)) != 32'd0) || (bus.sel_i == '0);
`else
    assign bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A reset on the commit edge must also veto the write, hence rst_i in wr_en.
    assign enter_resp = (state_d == RESP) && (state_q != RESP);
    assign wr_en      = enter_resp && bus.we_i && !bad && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_resp) begin
                err_q <= bad;
            end
        end
    end

    // Storage and its read register carry no reset so they can map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (enter_resp) begin
            rd_q <= mem[word_idx];
        end
        for (int k = 0; k < SEL_WIDTH; k++) begin
            if (wr_en && bus.sel_i[k]) begin
                mem[word_idx][8*k +: 8] <= bus.dat_i[8*k +: 8];
            end
        end
    end

    assign ack       = (state_q == RESP) && !err_q;
    assign bus.ack_o = ack;
    assign bus.err_o = (state_q == RESP) && err_q;
    assign bus.dat_o = ack ? rd_q : '0;
    assign bus.rty_o = 1'b0;
endmodule

// File: tb/tb_wb_ram.sv
// Scoreboard bench for wb_ram: four instances cover byte lanes, wait states, range edges, reset and a 64-bit bus.
module tb_wb_ram;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cyc = 4'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] adr = 32'h0;
    logic [7:0]  sel = 8'h0;
    logic [63:0] wdat = 64'h0;

    logic [3:0]  ack, err, rty;
    logic [63:0] dout [4];

    always #5 clk = ~clk;

`ifdef CRUSH_WB_RAM_ERR_EN
    localparam int ERRK = 1;
`else
    localparam int ERRK = 0;
`endif

    localparam int LAT_EXP [4] = '{1, 4, 3, 1};
    localparam int BYTES   [4] = '{4, 4, 4, 8};

    wb_ram_if #(.DATA_WIDTH(32)) bus0();
    wb_ram_if #(.DATA_WIDTH(32)) bus1();
    wb_ram_if #(.DATA_WIDTH(32)) bus2();
    wb_ram_if #(.DATA_WIDTH(64)) bus3();

    assign bus0.cyc_i = cyc[0]; assign bus0.stb_i = stb; assign bus0.adr_i = adr;
    assign bus0.sel_i = sel[3:0]; assign bus0.dat_i = wdat[31:0]; assign bus0.we_i = we;
    assign bus1.cyc_i = cyc[1]; assign bus1.stb_i = stb; assign bus1.adr_i = adr;
    assign bus1.sel_i = sel[3:0]; assign bus1.dat_i = wdat[31:0]; assign bus1.we_i = we;
    assign bus2.cyc_i = cyc[2]; assign bus2.stb_i = stb; assign bus2.adr_i = adr;
    assign bus2.sel_i = sel[3:0]; assign bus2.dat_i = wdat[31:0]; assign bus2.we_i = we;
    assign bus3.cyc_i = cyc[3]; assign bus3.stb_i = stb; assign bus3.adr_i = adr;
    assign bus3.sel_i = sel;      assign bus3.dat_i = wdat;       assign bus3.we_i = we;

    assign ack[0] = bus0.ack_o; assign err[0] = bus0.err_o; assign rty[0] = bus0.rty_o; assign dout[0] = {32'h0, bus0.dat_o};
    assign ack[1] = bus1.ack_o; assign err[1] = bus1.err_o; assign rty[1] = bus1.rty_o; assign dout[1] = {32'h0, bus1.dat_o};
    assign ack[2] = bus2.ack_o; assign err[2] = bus2.err_o; assign rty[2] = bus2.rty_o; assign dout[2] = {32'h0, bus2.dat_o};
    assign ack[3] = bus3.ack_o; assign err[3] = bus3.err_o; assign rty[3] = bus3.rty_o; assign dout[3] = bus3.dat_o;

    wb_ram #(.BASE_ADDRESS(32'h0001_0000), .SIZE_BYTES(1024), .DATA_WIDTH(32), .WAIT_STATES(0))
        u0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
    wb_ram #(.BASE_ADDRESS(32'h0000_0000), .SIZE_BYTES(16384), .DATA_WIDTH(32), .WAIT_STATES(3))
        u1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
    wb_ram #(.BASE_ADDRESS(32'hFFFF_FC00), .SIZE_BYTES(1024), .DATA_WIDTH(32), .WAIT_STATES(2))
        u2 (.clk_i(clk), .rst_i(rst), .bus(bus2));
    wb_ram #(.BASE_ADDRESS(32'h0000_0000), .SIZE_BYTES(16384), .DATA_WIDTH(64), .WAIT_STATES(0))
        u3 (.clk_i(clk), .rst_i(rst), .bus(bus3));

    typedef struct {
        int          d;
        int          kind;
        logic        chk;
        logic [63:0] data;
        int          t0;
    } exp_t;

    exp_t        sbq [$];
    logic [63:0] model [logic [33:0]];
    int          vectors = 0;
    int          miscompares = 0;
    int          ecnt = 0;
    int          rcnt [4] = '{0, 0, 0, 0};
    int          rtime [4] = '{0, 0, 0, 0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) ecnt <= ecnt + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            if (ack[d] || err[d]) begin
                check("ack_err_excl", 64'(ack[d] & err[d]), 64'd0);
                if (sbq.size() == 0) begin
                    check("unexpected_resp", 64'(d + 1), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check("resp_dut", 64'(d), 64'(e.d));
                    check("resp_kind", 64'(err[d]), 64'(e.kind));
                    if (e.chk) check("rdata", dout[d], e.data);
                    if (e.t0 >= 0) check("latency", 64'(ecnt - e.t0), 64'(LAT_EXP[d]));
                end
                rcnt[d]  = rcnt[d] + 1;
                rtime[d] = ecnt;
            end
        end
    end

    // kind: 0 = ack expected, 1 = err expected, 2 = no response (stb held 'hold' edges, then dropped)
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [7:0] s,
                        input logic [63:0] wd, input int kind, input int hold);
        exp_t        e;
        int          n0;
        logic [33:0] key;
        logic [63:0] m;
        key = {2'(d), a & ~32'(BYTES[d] - 1)};
        m   = model.exists(key) ? model[key] : 64'h0;
        @(negedge clk);
        adr = a; sel = s; wdat = wd; we = w; cyc[d] = 1'b1; stb = 1'b1;
        n0 = rcnt[d];
        if (kind != 2) begin
            e.d    = d;
            e.kind = kind;
            e.chk  = (kind == 1) || (!w && model.exists(key));
            e.data = (kind == 1) ? 64'h0 : m;
            e.t0   = ecnt;
            sbq.push_back(e);
            for (int i = 0; i < 40 && rcnt[d] == n0; i++) @(posedge clk);
            check("resp_seen", 64'(rcnt[d] - n0), 64'd1);
            if (rcnt[d] == n0) sbq.delete();
            if (kind == 0 && w) begin
                for (int k = 0; k < BYTES[d]; k++) if (s[k]) m[8*k +: 8] = wd[8*k +: 8];
                model[key] = m;
            end
        end else begin
            repeat (hold) @(posedge clk);
        end
        @(negedge clk);
        cyc[d] = 1'b0; stb = 1'b0;
        if (kind == 2) begin
            repeat (4) @(posedge clk);
            check("no_resp", 64'(rcnt[d] - n0), 64'd0);
        end else begin
            check("dat_idle", dout[d], 64'h0);
        end
    endtask

    initial begin : stim
        exp_t e;
        int   n0;
        int   got;
        int   t [4];
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 64'(ack), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        check("rst_dat0", dout[0], 64'h0);
        check("rst_dat3", dout[3], 64'h0);
        rst = 1'b0;

        // byte lanes, 32-bit, no wait states
        xfer(0, 1'b1, 32'h0001_0008, 8'hF, 64'h1122_3344, 0, 0);
        xfer(0, 1'b1, 32'h0001_0008, 8'h9, 64'hAA55_66BB, 0, 0);
        xfer(0, 1'b0, 32'h0001_0008, 8'hF, 64'h0, 0, 0);

        // range edges
        xfer(0, 1'b1, 32'h0001_03FC, 8'hF, 64'h5A5A_0FF0, 0, 0);
        xfer(0, 1'b0, 32'h0001_03FC, 8'hF, 64'h0, 0, 0);
        xfer(0, 1'b0, 32'h0001_0400, 8'hF, 64'h0, 2, 20);
        xfer(0, 1'b1, 32'h0000_FFFC, 8'hF, 64'h0BAD_0BAD, 2, 20);

        // misaligned and empty-sel accesses
        xfer(0, 1'b1, 32'h0001_0000, 8'hF, 64'h8765_4321, 0, 0);
        xfer(0, 1'b0, 32'h0001_0002, 8'hF, 64'h0, ERRK, 0);
        xfer(0, 1'b1, 32'h0001_0000, 8'h0, 64'hFFFF_FFFF, ERRK, 0);
        xfer(0, 1'b0, 32'h0001_0000, 8'hF, 64'h0, 0, 0);

        // wait states and aborts
        xfer(1, 1'b1, 32'h0000_0040, 8'hF, 64'hDEAD_0001, 0, 0);
        xfer(1, 1'b0, 32'h0000_0040, 8'hF, 64'h0, 0, 0);
        xfer(1, 1'b0, 32'h0000_0040, 8'hF, 64'h0, 2, 2);
        xfer(1, 1'b1, 32'h0000_0040, 8'hF, 64'hBAD0_BAD0, 2, 2);
        xfer(1, 1'b0, 32'h0000_0040, 8'hF, 64'h0, 0, 0);

        // window ending at 2^32
        xfer(2, 1'b1, 32'hFFFF_FFFC, 8'hF, 64'h600D_F00D, 0, 0);
        xfer(2, 1'b0, 32'hFFFF_FFFC, 8'hF, 64'h0, 0, 0);

        // reset one cycle into a write
        xfer(2, 1'b1, 32'hFFFF_FFF0, 8'hF, 64'hCAFE_BABE, 0, 0);
        @(negedge clk);
        adr = 32'hFFFF_FFF0; sel = 8'hF; wdat = 64'h1234_5678; we = 1'b1; cyc[2] = 1'b1; stb = 1'b1;
        n0 = rcnt[2];
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; cyc[2] = 1'b0; stb = 1'b0;
        check("rst_mid_ack", 64'(ack[2]), 64'd0);
        check("rst_mid_err", 64'(err[2]), 64'd0);
        check("rst_mid_dat", dout[2], 64'h0);
        repeat (4) @(posedge clk);
        check("rst_mid_noresp", 64'(rcnt[2] - n0), 64'd0);
        xfer(2, 1'b0, 32'hFFFF_FFF0, 8'hF, 64'h0, 0, 0);

        // 64-bit bus, upper lanes only
        xfer(3, 1'b1, 32'h0000_0010, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 0);
        xfer(3, 1'b1, 32'h0000_0010, 8'hF0, 64'hDEAD_BEEF_0000_0000, 0, 0);
        xfer(3, 1'b0, 32'h0000_0010, 8'hFF, 64'h0, 0, 0);

        // held strobe: one ack every two cycles
        @(negedge clk);
        adr = 32'h0000_0010; sel = 8'hFF; we = 1'b0; cyc[3] = 1'b1; stb = 1'b1;
        n0 = rcnt[3];
        for (int i = 0; i < 4; i++) begin
            e.d = 3; e.kind = 0; e.chk = 1'b1; e.data = model[{2'd3, 32'h0000_0010}]; e.t0 = -1;
            sbq.push_back(e);
        end
        got = 0;
        t = '{0, 0, 0, 0};
        for (int i = 0; i < 40 && got < 4; i++) begin
            @(posedge clk);
            if (rcnt[3] - n0 > got) begin
                t[got] = rtime[3];
                got++;
            end
        end
        @(negedge clk);
        cyc[3] = 1'b0; stb = 1'b0;
        check("b2b_count", 64'(got), 64'd4);
        for (int i = 1; i < 4; i++) check("b2b_gap", 64'(t[i] - t[i-1]), 64'd2);
        if (got < 4) sbq.delete();
        repeat (4) @(posedge clk);
        check("b2b_extra", 64'(rcnt[3] - n0), 64'd4);
        check("rty", 64'(rty), 64'h0);
        check("sb_empty", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
